wide_add_seq: RTL and testbench

- Multi-cycle sequencer that performs a WIDTH-bit add (optionally subtract) on one shared 32-bit carry-lookahead adder.
- Processes one 32-bit chunk per cycle, LSB chunk first, chaining the carry between chunks in a register.
- Sits between a valid/ready producer and consumer in the arithmetic datapath, and gives wide adds without replicating adder hardware.

---
 rtl/wide_add_pkg.sv | 28 ++
 rtl/wide_add_seq_cla.sv | 77 +++++++
 rtl/wide_add_seq.sv | 147 ++++++++++++++
 tb/tb_wide_add_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wide_add_pkg
// Purpose : Shared definitions for the wide_add_seq multi-cycle adder:
//           per-cycle chunk width, sequencer state type and a helper that
//           derives the number of chunks from the operand width.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package wide_add_pkg;

  // Width of the shared adder; the sequencer processes this many bits/cycle.
  localparam int CHUNK_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Number of RUN cycles needed for an operand of the given width.
  function automatic int chunk_count(input int width);
    return width / CHUNK_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wide_add_seq_cla.sv
`default_nettype none
// ============================================================================
// Module  : wide_add_seq_cla
// Purpose : 32-bit two-level carry-lookahead adder. Bits are grouped in
//           nibbles; group generate/propagate terms feed a second lookahead
//           level that produces every group carry-in directly from i_cin.
// Ports   : i_a    [31:0] in  addend A
//           i_b    [31:0] in  addend B
//           i_cin         in  carry into bit 0
//           o_sum  [32:0] out sum; bit 32 is the carry-out
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module wide_add_seq_cla
  import wide_add_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_a,
  input  logic [CHUNK_W-1:0] i_b,
  input  logic               i_cin,
  output logic [CHUNK_W:0]   o_sum
);

  localparam int c_NGRP = CHUNK_W / 4;

  // Carry into position n of an up-to-8-wide lookahead block, written in the
  // flat sum-of-products form so every carry is two gate levels from g/p:
  //   c[n] = cin&p[0..n-1] | g[0]&p[1..n-1] | ... | g[n-1]
  function automatic logic la_carry(input logic [7:0] g, input logic [7:0] p,
                                    input logic cin, input int n);
    logic c;
    logic t;
    c = cin;
    t = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) c = c & p[k];
    end
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        t = g[i];
        for (int k = 0; k < 8; k++) begin
          if (k > i && k < n) t = t & p[k];
        end
        c = c | t;
      end
    end
    return c;
  endfunction

  logic [CHUNK_W-1:0] w_g;
  logic [CHUNK_W-1:0] w_p;
  logic [CHUNK_W-1:0] w_c;
  logic [c_NGRP-1:0]  w_gg;
  logic [c_NGRP-1:0]  w_gp;
  logic [c_NGRP:0]    w_cg;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  generate
    for (genvar j = 0; j < c_NGRP; j++) begin : g_grp
      // Group generate: carry out of the nibble with zero carry in.
      assign w_gg[j] = la_carry({4'b0, w_g[4*j +: 4]}, {4'b0, w_p[4*j +: 4]}, 1'b0, 4);
      assign w_gp[j] = &w_p[4*j +: 4];
      for (genvar i = 0; i < 4; i++) begin : g_bit
        assign w_c[4*j+i] = la_carry({4'b0, w_g[4*j +: 4]}, {4'b0, w_p[4*j +: 4]},
                                     w_cg[j], i);
      end
    end
    for (genvar j = 0; j <= c_NGRP; j++) begin : g_gcarry
      assign w_cg[j] = la_carry(w_gg, w_gp, i_cin, j);
    end
  endgenerate

  assign o_sum = {w_cg[c_NGRP], w_p ^ w_c};

endmodule
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : wide_add_seq
// Purpose : Multi-cycle WIDTH-bit adder built on one shared 32-bit CLA. One
//           chunk is added per cycle, LSB first, with the carry chained
//           through a register. Valid/ready on both operand and result side.
// Ports   : clk                 in  rising-edge clock
//           rst                 in  synchronous active-high reset
//           in_valid / in_ready in/out operand handshake
//           a, b  [WIDTH-1:0]   in  operands, sampled at accept
//           c_in                in  carry into bit 0, sampled at accept
//           sub                 in  1 = a-b (only with WIDE_ADD_SEQ_ADD_SUB_EN)
//           out_valid/out_ready out/in result handshake
//           sum   [WIDTH:0]     out result, bit WIDTH = final carry-out
//           busy                out high while RUN or DONE
// Config  : `define WIDE_ADD_SEQ_ADD_SUB_EN to add the sub port and the
//           subtract path (b inverted, carry forced to 1).
// Revision: 1.0 - initial release
// ============================================================================
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef WIDE_ADD_SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int NCHUNK = chunk_count(WIDTH);
  localparam int IDX_W  = $clog2(NCHUNK);

  generate
    if (CHUNK != CHUNK_W) begin : g_bad_chunk
      $error("wide_add_seq: CHUNK must be 32");
    end
    if ((WIDTH < 64) || ((WIDTH % CHUNK_W) != 0)) begin : g_bad_width
      $error("wide_add_seq: WIDTH must be a multiple of 32 and >= 64");
    end
  endgenerate

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH:0]   r_sum;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [CHUNK_W:0] w_add;

  // Operand conditioning at accept time.
`ifdef WIDE_ADD_SEQ_ADD_SUB_EN
  // a - b = a + ~b + 1; c_in is ignored for a subtract.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : c_in;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = c_in;
`endif

  assign in_ready  = (r_state == IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;

  // Operand registers shift down one chunk per RUN cycle, so the low chunk
  // is always the one for the current index; no wide mux on the adder input.
  wide_add_seq_cla u_cla (
    .i_a  (r_a[CHUNK_W-1:0]),
    .i_b  (r_b[CHUNK_W-1:0]),
    .i_cin(r_carry),
    .o_sum(w_add)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK_W;
          r_b     <= r_b >> CHUNK_W;
          r_carry <= w_add[CHUNK_W];
          r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
          // Result chunks are written in place; older chunks of the previous
          // result remain visible until overwritten.
          for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) r_sum[k*CHUNK_W +: CHUNK_W] <= w_add[CHUNK_W-1:0];
          end
          if (w_last) r_sum[WIDTH] <= w_add[CHUNK_W];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_wide_add_seq
// Purpose : Self-checking bench for wide_add_seq. Expected results come from
//           plain wide arithmetic on the operands as applied at accept.
// Config  : honours WIDE_ADD_SEQ_ADD_SUB_EN (drives sub and checks a-b)
// Revision: 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

  localparam int W   = 128;
  localparam int NCH = W / 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  wide_add_seq #(.WIDTH(W), .CHUNK(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef WIDE_ADD_SEQ_ADD_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_w();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One complete transaction: accept, observe chunk-by-chunk progress,
  // hold the result for 'stall' cycles under backpressure, then release.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                       input logic tc, input logic ts, input int stall,
                       input bit disturb);
    logic [W:0] exp;
    logic [W:0] mask;
    int         cnt;
    if (ts) exp = {1'b0, ta} + {1'b0, ~tb_op} + (W+1)'(1);
    else    exp = {1'b0, ta} + {1'b0, tb_op} + (W+1)'(tc);

    chk("idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    a = ta; b = tb_op; c_in = tc; sub = ts;
    tick();
    // Operands must no longer matter after accept.
    in_valid = 1'b0;
    a = rnd_w(); b = rnd_w(); c_in = 1'($urandom()); sub = 1'($urandom());

    cnt = 0;
    while (!out_valid && cnt < 3 * NCH) begin
      if (disturb) out_ready = 1'($urandom());
      tick();
      cnt++;
      if (!out_valid) begin
        mask = ((W+1)'(1) << (cnt * 32)) - (W+1)'(1);
        chk("partial_sum", sum & mask, exp & mask);
        chk("run_in_ready", in_ready, 1'b0);
        chk("run_busy", busy, 1'b1);
      end
    end
    chk("latency", cnt, NCH);
    chk("result", sum, exp);

    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      // A second request during DONE must be ignored.
      in_valid = 1'b1;
      a = rnd_w(); b = rnd_w();
      tick();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_sum", sum, exp);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
    chk("idle_sum_kept", sum, exp);
  endtask

  initial begin
    logic [W-1:0] ones;
    bit           seen;
    ones      = '1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    tick();
    tick();
    chk("rst_in_ready_hold", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sum", sum, '0);
    chk("reset_in_ready", in_ready, 1'b1);

    // Basic add, consumer always ready.
    out_ready = 1'b1;
    do_op(128'd1, 128'd2, 1'b0, 1'b0, 0, 1'b0);

    // Carry ripples through every chunk boundary.
    do_op(ones, '0, 1'b1, 1'b0, 0, 1'b0);
    chk("ripple_carry_out", sum[W], 1'b1);

    // Backpressure for 10 cycles.
    do_op(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
          128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 1'b0, 10, 1'b0);

    // Reset during the second RUN cycle abandons the operation.
    in_valid = 1'b1; a = ones; b = ones; c_in = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    tick();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sum", sum, '0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < NCH + 2; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_output", seen, 1'b0);
    chk("midrst_idle", in_ready, 1'b1);

    // Reset and in_valid together: nothing accepted.
    rst = 1'b1; in_valid = 1'b1; a = 128'd5; b = 128'd6;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_wins_busy", busy, 1'b0);
    tick();
    chk("rst_wins_busy2", busy, 1'b0);
    chk("rst_wins_sum", sum, '0);

`ifdef WIDE_ADD_SEQ_ADD_SUB_EN
    do_op(128'h1_0000_0000, 128'd1, 1'b0, 1'b1, 0, 1'b0);
    chk("sub_no_borrow", sum, {1'b1, 96'd0, 32'hFFFF_FFFF});
    do_op(128'd0, 128'd1, 1'b1, 1'b1, 0, 1'b0);
    chk("sub_borrow", sum, {1'b0, ones});
`endif

    // Random regression with stalls and out_ready noise during RUN.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = rnd_w();
      rb = rnd_w();
      case ($urandom_range(0, 3))
        0: begin ra = ones; rb = W'($urandom_range(0, 3)); end
        1: rb = ~ra;
        default: ;
      endcase
`ifdef WIDE_ADD_SEQ_ADD_SUB_EN
      rs = 1'($urandom());
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, 1'($urandom()), rs, $urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
